fp_add_sched: RTL and testbench

Round-robin scheduler that shares a single `fp_add` pipeline between `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready ports and issues at most one pair per cycle. It tracks each issue's requester tag alongside the fixed-latency adder and returns tagged sums through a credit-protected result FIFO. It sits between the vector front-end and the single shared adder in the FP datapath.

---
 rtl/fp_add_sched_pkg.sv | 11 +
 rtl/fp_add.sv | 74 +++++++
 rtl/fp_add_sched_fifo.sv | 47 ++++
 rtl/fp_add_sched.sv | 122 ++++++++++++
 tb/tb_fp_add_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the fp_add scheduling slice.
// Used by the scheduler top, its result FIFO and the shared adder.
package fp_add_sched_pkg;
    localparam int FP_ADD_LAT = 4;

    typedef logic [31:0] fp32_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/fp_add.sv
// Shared fp32 adder, 4 registered stages, no backpressure; truncating rounding.
// Zero/denormal operands carry no hidden bit; Inf/NaN are not specially propagated.
import fp_add_sched_pkg::*;

module fp_add (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_vld,
    input  fp32_t a,
    input  fp32_t b,
    output logic  sum_vld,
    output fp32_t sum
);
    logic        a_big;
    fp32_t       big;
    fp32_t       sml;
    logic [7:0]  d;
    logic [25:0] m_big;
    logic [25:0] m_sml;

    logic        v1, s1, sub1, v2, s2, v3;
    logic [7:0]  e1, e2;
    logic [25:0] mb1, ms1;
    logic [26:0] mag2;
    logic [4:0]  lz;
    logic [25:0] norm;
    fp32_t       res_n, r3;

    assign a_big = (a[30:0] >= b[30:0]);
    assign big   = a_big ? a : b;
    assign sml   = a_big ? b : a;
    assign d     = big[30:23] - sml[30:23];
    assign m_big = {|big[30:23], big[22:0], 2'b00};
    assign m_sml = {|sml[30:23], sml[22:0], 2'b00};

    // Normalise: carry-out shifts right one, otherwise shift the leading one up to bit 25.
    always_comb begin
        lz = '0;
        for (int i = 0; i < 26; i++)
            if (mag2[i]) lz = 5'(25 - i);
        norm  = mag2[25:0] << lz;
        res_n = '0;
        if (mag2[26]) begin
            if (e2 == 8'd254) res_n = {s2, 8'hFF, 23'd0};
            else              res_n = {s2, e2 + 8'd1, mag2[25:3]};
        end else if ((mag2[25:0] != '0) && (e2 > {3'b000, lz})) begin
            res_n = {s2, e2 - {3'b000, lz}, norm[24:2]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0; s1 <= 1'b0; sub1 <= 1'b0; e1 <= '0; mb1 <= '0; ms1 <= '0;
            v2 <= 1'b0; s2 <= 1'b0; e2 <= '0; mag2 <= '0;
            v3 <= 1'b0; r3 <= '0;
            sum_vld <= 1'b0; sum <= '0;
        end else begin
            v1   <= in_vld;
            s1   <= big[31];
            sub1 <= big[31] ^ sml[31];
            e1   <= big[30:23];
            mb1  <= m_big;
            ms1  <= (d > 8'd25) ? '0 : (m_sml >> d);
            v2   <= v1;
            s2   <= s1;
            e2   <= e1;
            mag2 <= sub1 ? ({1'b0, mb1} - {1'b0, ms1}) : ({1'b0, mb1} + {1'b0, ms1});
            v3   <= v2;
            r3   <= res_n;
            sum_vld <= v3;
            sum     <= r3;
        end
    end
endmodule

// File: rtl/fp_add_sched_fifo.sv
// Sync FWFT result FIFO, registered storage; data visible the cycle after push.
// No backpressure of its own: the caller guarantees push is never issued while full without a pop.
import fp_add_sched_pkg::*;

module fp_add_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Gate the head so the data outputs read zero whenever nothing is queued.
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
endmodule

// File: rtl/fp_add_sched.sv
// Round-robin sharing of one fp_add among NUM_REQ requesters; issue to res_vld is 6 cycles.
// Credits cover S0 + adder + FIFO, so req_rdy drops when FIFO_DEPTH results are owed; FP_ADD_SCHED_STATS_EN adds grant_cnt.
import fp_add_sched_pkg::*;

module fp_add_sched #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_vld,
    output logic [NUM_REQ-1:0]   req_rdy,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output fp32_t                res_sum,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 busy
`ifdef FP_ADD_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed { logic [TAG_W-1:0] tag; fp32_t sum; } res_t;
    typedef struct packed { logic vld; logic [TAG_W-1:0] tag; } tp_t;

    logic [TAG_W-1:0]        rr_ptr, gnt_idx, s0_tag;
    logic                    gnt_any, credit_ok, issue, pop, fifo_empty;
    logic [CW-1:0]           cred_cnt;
    logic                    s0_vld, add_vld;
    fp32_t                   s0_a, s0_b, add_sum;
    tp_t [FP_ADD_LAT-1:0]    tpipe;
    res_t                    head;

    // Scan from the highest wrap offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_vld[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign credit_ok = (cred_cnt < CW'(FIFO_DEPTH));
    assign issue     = gnt_any && credit_ok && rst;
    assign req_rdy   = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign pop       = res_vld && res_rdy;
    assign busy      = (cred_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            cred_cnt <= '0;
            s0_vld   <= 1'b0;
            s0_tag   <= '0;
            s0_a     <= '0;
            s0_b     <= '0;
            tpipe    <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                s0_tag <= gnt_idx;
                s0_a   <= req_a[gnt_idx*32 +: 32];
                s0_b   <= req_b[gnt_idx*32 +: 32];
            end
            s0_vld <= issue;
            tpipe  <= {tpipe[FP_ADD_LAT-2:0], tp_t'{vld: s0_vld, tag: s0_tag}};
            case ({issue, pop})
                2'b10:   cred_cnt <= cred_cnt + 1'b1;
                2'b01:   cred_cnt <= cred_cnt - 1'b1;
                default: cred_cnt <= cred_cnt;
            endcase
        end
    end

    fp_add u_add (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s0_vld),
        .a       (s0_a),
        .b       (s0_b),
        .sum_vld (add_vld),
        .sum     (add_sum)
    );

    // The tag pipe, not the adder's valid, drives the push so reset can never leave phantoms.
    fp_add_sched_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(res_t))) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tpipe[FP_ADD_LAT-1].vld),
        .push_dat (res_t'{tag: tpipe[FP_ADD_LAT-1].tag, sum: add_sum}),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (fifo_empty)
    );

    assign res_vld = !fifo_empty;
    assign res_sum = head.sum;
    assign res_tag = head.tag;

    a_lockstep: assert property (@(posedge clk) disable iff (!rst) add_vld == tpipe[FP_ADD_LAT-1].vld);

`ifdef FP_ADD_SCHED_STATS_EN
    logic [NUM_REQ-1:0][15:0] gcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            gcnt <= '0;
        else if (issue)
            gcnt[gnt_idx] <= sat_inc16(gcnt[gnt_idx]);
    end

    assign grant_cnt = gcnt;
`endif
endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched: arbitration/credit model checked each cycle, results via queue.
module tb_fp_add_sched;
    localparam int N = 4;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_vld = '0;
    logic [N-1:0]  req_rdy;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic          res_vld;
    logic          res_rdy = 1'b0;
    logic [31:0]   res_sum;
    logic [1:0]    res_tag;
    logic          busy;
`ifdef FP_ADD_SCHED_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    typedef struct { logic [31:0] sum; int tag; int cyc; bit exact; } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   issued = 0, popped = 0, m_rr = 0;
    int   tally[N];
    real  opa[N], opb[N];
    bit   exact_mode = 1'b1;

    fp_add_sched #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_a   (req_a),
        .req_b   (req_b),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res_sum (res_sum),
        .res_tag (res_tag),
        .busy    (busy)
`ifdef FP_ADD_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // IEEE single encoding of an exactly representable real value.
    function automatic logic [31:0] fp_of(input real v);
        real  m;
        int   e, frac;
        logic s;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        frac = int'((m - 1.0) * 8388608.0);
        return {s, 8'(e + 127), 23'(frac)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            opa[i] = real'(int'($urandom_range(0, 2000)) - 1000);
            opb[i] = real'(int'($urandom_range(0, 2000)) - 1000);
        end
    endtask

    // Called at a negedge: drive, predict grant, record issues, advance to the next negedge.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = fp_of(opa[i]);
            req_b[i*32 +: 32] = fp_of(opb[i]);
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && req_vld[(m_rr + k) % N]) g = (m_rr + k) % N;
        exp_rdy = (g >= 0 && rst && (issued - popped) < D) ? (N'(1) << g) : '0;
        check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (req_vld[i] && req_rdy[i]) begin
                sbq.push_back('{fp_of(opa[i] + opb[i]), i, cyc + 6, exact_mode});
                issued++;
                tally[i]++;
                m_rr = (i + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req_vld = '0;
        res_rdy = 1'b1;
        for (int k = 0; k < 64 && (sbq.size() != 0 || busy); k++) step();
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (res_vld && sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL phantom_result: res_vld=1 sum=%h tag=%0d with nothing expected (cycle %0d)",
                         res_sum, res_tag, cyc);
                if (res_rdy) popped++;
            end else if (res_vld && res_rdy) begin
                e = sbq.pop_front();
                check("res_sum", res_sum, e.sum);
                check("res_tag", 32'(res_tag), 32'(e.tag));
                if (e.exact) check("latency_exact", 32'(cyc), 32'(e.cyc));
                else         check("latency_min", 32'(cyc >= e.cyc), 32'd1);
                popped++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n0;
        for (int i = 0; i < N; i++) tally[i] = 0;
        rand_ops();
        req_vld = '1;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_res_vld", 32'(res_vld), 32'd0);
        check("rst_res_sum", res_sum, 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef FP_ADD_SCHED_STATS_EN
        check("rst_grant_cnt_lo", grant_cnt[31:0], 32'd0);
        check("rst_grant_cnt_hi", grant_cnt[63:32], 32'd0);
`endif
        req_vld = '0;
        rst = 1'b1;

        // Round-robin with all requesters streaming.
        res_rdy = 1'b1;
        req_vld = '1;
        repeat (8) begin rand_ops(); step(); end
        drain();

        // Single op from requester 2: 1.0 + 1.0.
        opa[2] = 1.0; opb[2] = 1.0;
        req_vld = 4'b0100;
        step();
        drain();

        // Full rate from requester 1: 1.5 + 1.5 for 20 cycles.
        opa[1] = 1.5; opb[1] = 1.5;
        req_vld = 4'b0010;
        repeat (20) step();
        drain();

        // Backpressure: credits must stop issue at FIFO_DEPTH.
        exact_mode = 1'b0;
        res_rdy = 1'b0;
        req_vld = '1;
        n0 = issued;
        repeat (20) begin rand_ops(); step(); end
        check("bp_issue_count", 32'(issued - n0), 32'(D));
        res_rdy = 1'b1;
        repeat (12) begin rand_ops(); step(); end
        drain();

        // Reset mid-flight discards everything in flight.
        rand_ops();
        req_vld = 4'b0001;
        repeat (3) step();
        rst = 1'b0;
        req_vld = '0;
        sbq.delete();
        issued = 0; popped = 0; m_rr = 0;
        for (int i = 0; i < N; i++) tally[i] = 0;
        repeat (2) step();
        rst = 1'b1;
        repeat (12) step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_res_vld", 32'(res_vld), 32'd0);

        // Credits fully restored after reset: exactly FIFO_DEPTH issues with consumer stalled.
        res_rdy = 1'b0;
        req_vld = '1;
        n0 = issued;
        repeat (14) begin rand_ops(); step(); end
        check("post_rst_credits", 32'(issued - n0), 32'(D));
        drain();

        // Randomised traffic and consumer stalls.
        repeat (300) begin
            rand_ops();
            req_vld = N'($urandom);
            res_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

`ifdef FP_ADD_SCHED_STATS_EN
        for (int i = 0; i < N; i++)
            check($sformatf("grant_cnt[%0d]", i), 32'(grant_cnt[i*16 +: 16]), 32'(tally[i]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
